// File: rtl/fb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter_if
// Bundles every non-clock signal of fb_port_arbiter.
//   LCD read side : iRdReq, iRdAddr  -> oRdData, oRdValid
//   Pixel writer  : iWrValid, iWrAddr, iWrData, iFlush -> oWrReady
//   RAM port      : oRamEn, oRamWe, oRamAddr, oRamWrData <- iRamRdData
//   Status        : oLastWrAddr, oFifoLevel, oWrStarve
// Modport "slave" is the arbiter's view; modport "master" is the view of
// the surrounding system (LCD controller, writer and RAM together).
// ---------------------------------------------------------------------------
interface fb_port_arbiter_if #(
  parameter int AW      = 17,
  parameter int DW      = 16,
  parameter int FIFO_AW = 3
);
  logic               iRdReq;
  logic [AW-1:0]      iRdAddr;
  logic [DW-1:0]      oRdData;
  logic               oRdValid;
  logic               iWrValid;
  logic               oWrReady;
  logic [AW-1:0]      iWrAddr;
  logic [DW-1:0]      iWrData;
  logic               iFlush;
  logic               oRamEn;
  logic               oRamWe;
  logic [AW-1:0]      oRamAddr;
  logic [DW-1:0]      oRamWrData;
  logic [DW-1:0]      iRamRdData;
  logic [AW-1:0]      oLastWrAddr;
  logic [FIFO_AW:0]   oFifoLevel;
  logic               oWrStarve;

  modport slave (
    input  iRdReq, iRdAddr, iWrValid, iWrAddr, iWrData, iFlush, iRamRdData,
    output oRdData, oRdValid, oWrReady, oRamEn, oRamWe, oRamAddr, oRamWrData,
           oLastWrAddr, oFifoLevel, oWrStarve
  );

  modport master (
    output iRdReq, iRdAddr, iWrValid, iWrAddr, iWrData, iFlush, iRamRdData,
    input  oRdData, oRdValid, oWrReady, oRamEn, oRamWe, oRamAddr, oRamWrData,
           oLastWrAddr, oFifoLevel, oWrStarve
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
// Shares one single-port, synchronous-read framebuffer RAM between the LCD
// scan-out reader and a pixel writer. Reads always win and have a fixed
// 3-cycle latency; writes queue in a small FIFO and are committed in cycles
// without a read. A starvation flag reports a writer that has been blocked
// for STARVE_LIM consecutive cycles.
// Ports:
//   iClk  - system clock
//   iRsn  - asynchronous active-low reset
//   bus   - fb_port_arbiter_if.slave (reader, writer, RAM and status signals)
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 16,
  parameter int FIFO_AW    = 3,
  parameter int STARVE_LIM = 600
) (
  input  logic                 iClk,
  input  logic                 iRsn,
  fb_port_arbiter_if.slave     bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} grant_e;

  entry_t           fifo_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  entry_t           head;
  grant_e           grant;

  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic [AW-1:0]    last_wr_q, last_wr_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic [CW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             starve_q, starve_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head       = fifo_q[rd_ptr_q[FIFO_AW-1:0]];

  // Gated by the reset pin itself so ready is low throughout reset and
  // follows the fill level as soon as reset is released.
  assign bus.oWrReady = iRsn & ~fifo_full;

  // Reads take the port unconditionally; a flush cycle never pops.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    grant = GNT_IDLE;
    if (bus.iRdReq)                        grant = GNT_READ;
    else if (!fifo_empty && !bus.iFlush)   grant = GNT_WRITE;
  end

  assign pop  = (grant == GNT_WRITE);
  assign push = bus.iWrValid & bus.oWrReady & ~bus.iFlush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.iFlush) begin
      rd_ptr_d = wr_ptr_q;            // drop everything; the same-cycle push is dropped too
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // RAM command for the next cycle; address and write data hold when idle.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    last_wr_d   = last_wr_q;
    unique case (grant)
      GNT_READ: begin
        ram_en_d   = 1'b1;
        ram_addr_d = bus.iRdAddr;
      end
      GNT_WRITE: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = head.addr;
        ram_wdata_d = head.data;
        last_wr_d   = head.addr;
      end
      default: ;
    endcase
  end

  // Read pipeline: command cycle -> RAM data cycle -> registered output.
  always_comb begin
    rd_pend_d  = ram_en_q & ~ram_we_q;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? bus.iRamRdData : rd_data_q;
  end

  always_comb begin
    if (!fifo_empty && !pop && !bus.iFlush)
      starve_cnt_d = (starve_cnt_q == CW'(STARVE_LIM)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    else
      starve_cnt_d = '0;
    starve_d = (starve_cnt_d == CW'(STARVE_LIM));
  end

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge iClk) begin
    if (push) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= {bus.iWrAddr, bus.iWrData};
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      last_wr_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      last_wr_q    <= last_wr_d;
      rd_pend_q    <= rd_pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.oRamEn      = ram_en_q;
  assign bus.oRamWe      = ram_we_q;
  assign bus.oRamAddr    = ram_addr_q;
  assign bus.oRamWrData  = ram_wdata_q;
  assign bus.oLastWrAddr = last_wr_q;
  assign bus.oRdValid    = rd_valid_q;
  assign bus.oRdData     = rd_data_q;
  assign bus.oFifoLevel  = wr_ptr_q - rd_ptr_q;
  assign bus.oWrStarve   = starve_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_port_arbiter
// Drives fb_port_arbiter with directed and randomized traffic, models the
// framebuffer RAM, and compares every cycle against a transaction-level
// reference: a pixel queue, a golden memory, and a list of reads with the
// cycle their data is due.
// ---------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int AW         = 17;
  localparam int DW         = 16;
  localparam int FIFO_AW    = 3;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int STARVE_LIM = 600;

  typedef logic [74:0] vec_t;

  logic iClk = 1'b0;
  logic iRsn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 iClk = ~iClk;

  fb_port_arbiter_if #(.AW(AW), .DW(DW), .FIFO_AW(FIFO_AW)) bus ();

  fb_port_arbiter #(.AW(AW), .DW(DW), .FIFO_AW(FIFO_AW), .STARVE_LIM(STARVE_LIM)) dut (
    .iClk (iClk),
    .iRsn (iRsn),
    .bus  (bus)
  );

  // Power-up contents of the framebuffer: a fixed hash of the address.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {15'd0, a} * 32'h9E37_79B1;
    return t[31:16];
  endfunction

  // ---------------- RAM model (single port, synchronous read) -------------
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  bit            ram_vld [0:(1<<AW)-1];
  logic [DW-1:0] ram_rd_q = '0;

  always @(posedge iClk) begin
    if (bus.oRamEn) begin
      if (bus.oRamWe) begin
        ram[bus.oRamAddr]     <= bus.oRamWrData;
        ram_vld[bus.oRamAddr] <= 1'b1;
      end else begin
        ram_rd_q <= ram_vld[bus.oRamAddr] ? ram[bus.oRamAddr] : init_val(bus.oRamAddr);
      end
    end
  end
  assign bus.iRamRdData = ram_rd_q;

  function automatic logic [DW-1:0] ram_peek(input logic [AW-1:0] a);
    return ram_vld[a] ? ram[a] : init_val(a);
  endfunction

  // ---------------- Reference model ---------------------------------------
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } px_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  px_t           m_fifo [$];
  rd_t           m_reads [$];
  logic [DW-1:0] gold [int];
  int            cyc = 0;
  int            m_starve_cnt = 0;
  bit            m_pop, m_push;
  px_t           m_head;
  logic          e_rd_valid = 1'b0;
  logic [DW-1:0] e_rd_data  = '0;
  logic          e_en = 1'b0, e_we = 1'b0, e_starve = 1'b0;
  logic [AW-1:0] e_addr = '0, e_last = '0;
  logic [DW-1:0] e_wdata = '0;

  function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : init_val(a);
  endfunction

  function automatic logic m_ready();
    return iRsn && (m_fifo.size() < DEPTH);
  endfunction

  always @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      m_fifo.delete();
      m_reads.delete();
      m_starve_cnt = 0;
      e_rd_valid = 1'b0; e_rd_data = '0; e_en = 1'b0; e_we = 1'b0;
      e_addr = '0; e_wdata = '0; e_last = '0; e_starve = 1'b0;
    end else begin
      m_pop  = !bus.iRdReq && (m_fifo.size() != 0) && !bus.iFlush;
      m_push = bus.iWrValid && (m_fifo.size() < DEPTH) && !bus.iFlush;
      if ((m_fifo.size() != 0) && !m_pop && !bus.iFlush)
        m_starve_cnt = (m_starve_cnt < STARVE_LIM) ? m_starve_cnt + 1 : STARVE_LIM;
      else
        m_starve_cnt = 0;
      e_starve = (m_starve_cnt == STARVE_LIM);
      if (bus.iRdReq) begin
        e_en = 1'b1; e_we = 1'b0; e_addr = bus.iRdAddr;
        m_reads.push_back('{cyc + 3, gold_rd(bus.iRdAddr)});
      end else if (m_pop) begin
        m_head = m_fifo.pop_front();
        gold[int'(m_head.addr)] = m_head.data;
        e_en = 1'b1; e_we = 1'b1; e_addr = m_head.addr; e_wdata = m_head.data;
        e_last = m_head.addr;
      end else begin
        e_en = 1'b0; e_we = 1'b0;
      end
      if (bus.iFlush)    m_fifo.delete();
      else if (m_push)   m_fifo.push_back('{bus.iWrAddr, bus.iWrData});
      cyc++;
      e_rd_valid = 1'b0;
      if ((m_reads.size() != 0) && (m_reads[0].due == cyc)) begin
        e_rd_valid = 1'b1;
        e_rd_data  = m_reads.pop_front().data;
      end
    end
  end

  function automatic vec_t obs_vec();
    return {bus.oRdValid, bus.oRdValid ? bus.oRdData : 16'h0, bus.oWrReady, bus.oRamEn,
            bus.oRamWe, bus.oRamAddr, bus.oRamWrData, bus.oLastWrAddr, bus.oFifoLevel,
            bus.oWrStarve};
  endfunction

  function automatic vec_t exp_vec();
    return {e_rd_valid, e_rd_valid ? e_rd_data : 16'h0, m_ready(), e_en, e_we, e_addr,
            e_wdata, e_last, 4'(m_fifo.size()), e_starve};
  endfunction

  function automatic vec_t raw_vec();
    return {bus.oRdValid, bus.oRdData, bus.oWrReady, bus.oRamEn, bus.oRamWe, bus.oRamAddr,
            bus.oRamWrData, bus.oLastWrAddr, bus.oFifoLevel, bus.oWrStarve};
  endfunction

  task automatic idle_inputs();
    bus.iRdReq = 1'b0; bus.iRdAddr = '0; bus.iWrValid = 1'b0;
    bus.iWrAddr = '0; bus.iWrData = '0; bus.iFlush = 1'b0;
  endtask

  // ---------------- Tests --------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge iClk);
    n_tests++;
    if (raw_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", raw_vec());
    end
    iRsn = 1'b1;
    @(negedge iClk);
    n_tests++;
    if (bus.oWrReady !== 1'b1 || bus.oFifoLevel !== 4'd0) begin
      n_fail++; $display("FAIL reset_release ready=%b level=%0d want 1/0", bus.oWrReady, bus.oFifoLevel);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reads_only();
    int first_valid = -1, n_valid = 0, last_valid = -1;
    bit we_seen = 0;
    for (int c = 0; c < 16; c++) begin
      bus.iRdReq  = (c < 10);
      bus.iRdAddr = (c < 10) ? AW'(c) : '0;
      @(negedge iClk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reads_only c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.oRdValid) begin
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        n_valid++;
      end
      if (bus.oRamWe) we_seen = 1;
    end
    n_tests++;
    if (first_valid != 2 || n_valid != 10 || last_valid != 11 || we_seen) begin
      n_fail++;
      $display("FAIL reads_latency first=%0d n=%0d last=%0d we=%0d want 2/10/11/0",
               first_valid, n_valid, last_valid, we_seen);
    end
  endtask

  task automatic test_writes_only();
    int i = 0, n_com = 0;
    bit acc;
    logic [AW-1:0] com_a [8];
    logic [DW-1:0] com_d [8];
    idle_inputs();
    for (int c = 0; c < 24; c++) begin
      bus.iWrValid = (i < 8);
      bus.iWrAddr  = AW'(100 + i);
      bus.iWrData  = DW'(16'hF800 + i);
      acc = bus.iWrValid && m_ready();
      @(negedge iClk);
      if (acc) i++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL writes_only c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.oRamWe && n_com < 8) begin
        com_a[n_com] = bus.oRamAddr; com_d[n_com] = bus.oRamWrData; n_com++;
      end
    end
    n_tests++;
    if (n_com != 8 || bus.oLastWrAddr !== 17'd107 || bus.oFifoLevel !== 4'd0) begin
      n_fail++; $display("FAIL writes_end commits=%0d last=%0d level=%0d want 8/107/0",
                         n_com, bus.oLastWrAddr, bus.oFifoLevel);
    end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (com_a[k] !== AW'(100 + k) || com_d[k] !== DW'(16'hF800 + k) ||
          ram_peek(AW'(100 + k)) !== DW'(16'hF800 + k)) begin
        n_fail++; $display("FAIL writes_order k=%0d addr=%0d data=%h ram=%h want %0d/%h",
                           k, com_a[k], com_d[k], ram_peek(AW'(100 + k)), 100 + k, 16'hF800 + k);
      end
    end
  endtask

  task automatic test_full();
    int i = 0, n_com = 0, first_we = -1, accept_it = -1;
    bit acc;
    logic [AW-1:0] com_a [9];
    idle_inputs();
    for (int c = 0; c < 50; c++) begin
      bus.iRdReq   = (c < 20);
      bus.iRdAddr  = AW'($urandom_range(1023));
      bus.iWrValid = (i < 9);
      bus.iWrAddr  = AW'(200 + i);
      bus.iWrData  = DW'(16'h0700 + i);
      acc = bus.iWrValid && m_ready();
      if (acc && i == 8) accept_it = c - 20;
      @(negedge iClk);
      if (acc) i++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL full c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 19) begin
        n_tests++;
        if (bus.oFifoLevel !== 4'd8 || bus.oWrReady !== 1'b0 || i != 8) begin
          n_fail++; $display("FAIL full_backpressure level=%0d ready=%b pushed=%0d want 8/0/8",
                             bus.oFifoLevel, bus.oWrReady, i);
        end
      end
      if (bus.oRamWe) begin
        if (first_we < 0) first_we = c - 20;
        if (n_com < 9) com_a[n_com] = bus.oRamAddr;
        n_com++;
      end
    end
    n_tests++;
    if (n_com != 9 || accept_it != first_we + 1) begin
      n_fail++; $display("FAIL full_drain commits=%0d accept=%0d first_pop=%0d want 9 and accept=first_pop+1",
                         n_com, accept_it, first_we);
    end
    for (int k = 0; k < 9 && k < n_com; k++) begin
      n_tests++;
      if (com_a[k] !== AW'(200 + k)) begin
        n_fail++; $display("FAIL full_order k=%0d addr=%0d want %0d", k, com_a[k], 200 + k);
      end
    end
  endtask

  task automatic test_starve();
    int first_st = -1, drops = 0;
    idle_inputs();
    for (int c = 0; c < 612; c++) begin
      bus.iRdReq   = (c < 610);
      bus.iRdAddr  = AW'($urandom_range(1023));
      bus.iWrValid = (c == 0);
      bus.iWrAddr  = AW'(300);
      bus.iWrData  = DW'($urandom);
      @(negedge iClk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL starve c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.oWrStarve && first_st < 0) first_st = c;
      if (c >= 600 && c < 610 && !bus.oWrStarve) drops++;
      if (c == 610) begin
        n_tests++;
        if (bus.oWrStarve !== 1'b0 || bus.oRamWe !== 1'b1) begin
          n_fail++; $display("FAIL starve_clear starve=%b we=%b want 0/1", bus.oWrStarve, bus.oRamWe);
        end
      end
    end
    n_tests++;
    if (first_st != 600 || drops != 0) begin
      n_fail++; $display("FAIL starve_onset first=%0d drops=%0d want 600/0", first_st, drops);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.iRdReq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.iRdAddr  = AW'($urandom_range(1023));
      bus.iWrValid = 1'b1;
      bus.iWrAddr  = AW'(400 + c);
      bus.iWrData  = DW'($urandom);
      @(negedge iClk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush_fill c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (bus.oFifoLevel !== 4'd5) begin
      n_fail++; $display("FAIL flush_level_before got %0d want 5", bus.oFifoLevel);
    end
    bus.iRdReq = 1'b0; bus.iFlush = 1'b1; bus.iWrAddr = AW'(999);
    @(negedge iClk);
    n_tests++;
    if (bus.oFifoLevel !== 4'd0 || bus.oRamWe !== 1'b0 || bus.oLastWrAddr !== 17'd300) begin
      n_fail++; $display("FAIL flush_now level=%0d we=%b last=%0d want 0/0/300",
                         bus.oFifoLevel, bus.oRamWe, bus.oLastWrAddr);
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge iClk);
      n_tests++;
      if (bus.oRamWe !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush_after c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_interleave();
    int n_req = 0, n_val = 0;
    bit acc = 1;
    idle_inputs();
    for (int c = 0; c < 204; c++) begin
      bus.iRdReq  = (c < 200) && (c % 2 == 0);
      bus.iRdAddr = AW'($urandom_range(63));
      if (!bus.iWrValid || acc) begin
        bus.iWrValid = (c < 200) && ($urandom_range(3) != 0);
        bus.iWrAddr  = AW'($urandom_range(63));
        bus.iWrData  = DW'($urandom);
      end
      acc = bus.iWrValid && m_ready();
      if (bus.iRdReq) n_req++;
      @(negedge iClk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL interleave c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      n_tests++;
      if (bus.oRamWe && bus.iRdReq) begin
        n_fail++; $display("FAIL interleave_slot c=%0d write committed in a read slot", c);
      end
      if (bus.oRdValid) n_val++;
    end
    n_tests++;
    if (n_val != n_req) begin
      n_fail++; $display("FAIL interleave_reads got %0d valids want %0d", n_val, n_req);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    idle_inputs();
    for (int c = 0; c < 30; c++) begin
      bus.iRdReq   = 1'b1;
      bus.iRdAddr  = AW'($urandom_range(63));
      bus.iWrValid = 1'b1;
      bus.iWrAddr  = AW'($urandom_range(63));
      bus.iWrData  = DW'($urandom);
      @(negedge iClk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid_pre c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
    #2 iRsn = 1'b0;
    #1;
    n_tests++;
    if (raw_vec() !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs got %h want 0", raw_vec());
    end
    repeat (2) @(negedge iClk);
    iRsn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge iClk);
      if (bus.oRdValid) stray++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid_post c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++; $display("FAIL reset_mid_stray got %0d valids want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_reads_only();
    test_writes_only();
    test_full();
    test_starve();
    test_flush();
    test_interleave();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
